// File: rtl/step_counter_pkg.sv
// rtl/step_counter_pkg.sv - shared state encoding and helpers for the step counter
// Holds the FSM state type and the log2 helper used to build the STEP alignment mask.
package step_counter_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RUN_UP = 2'b01,
    RUN_DN = 2'b10
  } state_t;

  function automatic int clog2(input int value);
    int result = 0;
    for (int i = 0; i < 31; i++) begin
      if (((value - 1) >> i) != 0) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/step_counter_tick_gen.sv
// rtl/step_counter_tick_gen.sv - free-running divider producing a one-cycle enable strobe
// The strobe is decoded from the counter register, so it is glitch-free and on the board clock.
module tick_gen #(
  parameter int DIV_WIDTH = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  logic [DIV_WIDTH-1:0] r_div_cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
    end
  end

  assign tick = &r_div_cnt;

endmodule

// File: rtl/step_counter_fsm.sv
// rtl/step_counter_fsm.sv - parametrised up/down step counter with load, wrap/saturate and flags
// Mode is latched from en/count_up on each tick or load; the step on a tick uses that new mode.
module step_counter_fsm
  import step_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int STEP      = 2,
  parameter int MAX_COUNT = 6,
  parameter int DIV_WIDTH = 26,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             count_up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count_value,
  output logic             tick,
  output logic             limit,
  output logic             at_zero,
  output logic             at_max
);

  localparam int               ALIGN_BITS = clog2(STEP);
  localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   MAX_EXT    = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0]   STEP_EXT   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'((1 << ALIGN_BITS) - 1);

  state_t           r_state, w_state_nxt, w_mode;
  logic [WIDTH-1:0] r_count, w_count_nxt, w_load_clip;
  logic             r_limit, w_limit_nxt, w_tick;
  logic [WIDTH:0]   w_up_sum, w_dn_diff;

  tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .tick  (w_tick)
  );

  // One extra bit so overflow past MAX_COUNT and underflow below zero are both visible.
  assign w_up_sum    = {1'b0, r_count} + STEP_EXT;
  assign w_dn_diff   = {1'b0, r_count} - STEP_EXT;
  assign w_load_clip = (load_value > MAX_W) ? MAX_W : load_value;

  always_comb begin
    w_mode = HOLD;
    if (en) w_mode = count_up ? RUN_UP : RUN_DN;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_limit_nxt = 1'b0;
    if (load) begin
      w_state_nxt = w_mode;
      w_count_nxt = w_load_clip & ALIGN_MASK;
    end else if (w_tick) begin
      w_state_nxt = w_mode;
      case (w_mode)
        RUN_UP: begin
          if (w_up_sum > MAX_EXT) begin
            w_limit_nxt = 1'b1;
            w_count_nxt = (SATURATE != 0) ? MAX_W : '0;
          end else begin
            w_count_nxt = w_up_sum[WIDTH-1:0];
          end
        end
        RUN_DN: begin
          if (w_dn_diff[WIDTH]) begin
            w_limit_nxt = 1'b1;
            w_count_nxt = (SATURATE != 0) ? '0 : MAX_W;
          end else begin
            w_count_nxt = w_dn_diff[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= HOLD;
      r_count <= '0;
      r_limit <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_limit <= w_limit_nxt;
    end
  end

  assign count_value = r_count;
  assign tick        = w_tick;
  assign limit       = r_limit;
  assign at_zero     = (r_count == '0);
  assign at_max      = (r_count == MAX_W);

endmodule
